uart_dec_line_parser: RTL and testbench
=======================================

// Module: uart_dec_line_parser
// PURPOSE
//  Sits between the UART Receiver (data_out/data_ready) and the adder datapath.
//  Consumes the ASCII byte stream, assembles decimal numbers terminated by CR or LF,
//  and presents them as binary values. Successive numbers pair up as operand A then
//  operand B, so the adder gets a stable, validated operand pair instead of raw buffer slots.
// PARAMETERS
//  WIDTH   8   width of each parsed number; legal values 0 .. 2**WIDTH-1
//  DIGITS  3   maximum decimal digits per number (1..9)
// PORTS
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-high reset
//  clr        in   1      synchronous clear: same effect as reset, but on a clock edge
//  rx_data    in   8      received byte (Receiver data_out)
//  rx_valid   in   1      1-cycle strobe, rx_data valid (Receiver data_ready)
//  num_out    out  WIDTH  last accepted number
//  num_valid  out  1      1-cycle strobe, num_out updated
//  num_idx    out  1      0 = num_out is operand A, 1 = operand B
//  num_a      out  WIDTH  operand A of the current/last pair
//  num_b      out  WIDTH  operand B of the last complete pair
//  pair_valid out  1      1-cycle strobe, num_a/num_b form a new complete pair
//  err        out  1      1-cycle strobe, malformed input detected
//  err_code   out  2      01 bad char, 10 too many digits, 11 overflow; holds until next err
// BEHAVIOUR
//  Reset/clr: state IDLE; acc, digit count and num_idx = 0.
//   All outputs = 0, strobes deasserted.
//  Bytes are examined only when rx_valid=1. Any rate is accepted, including back-to-back
//   every cycle; there is no backpressure.
//  Classes: digit = 0x30..0x39; terminator = 0x0D or 0x0A; everything else = bad.
//  FSM states: IDLE, DIGITS, DISCARD.
//   IDLE + digit: acc = d, cnt = 1, go DIGITS.
//   IDLE + terminator: ignored (empty line, CRLF second half). No output.
//   IDLE + bad: err, code 01, go DISCARD.
//   DIGITS + digit:
//    - cnt == DIGITS: err, code 10, go DISCARD.
//    - else nxt = acc*10 + d, computed in WIDTH+4 bits.
//    - nxt > 2**WIDTH-1: err, code 11, go DISCARD.
//    - otherwise acc = nxt, cnt += 1.
//   DIGITS + terminator: accept the number, go IDLE.
//   DIGITS + bad: err, code 01, go DISCARD.
//   DISCARD: drop every byte; terminator returns to IDLE. No number output, num_idx unchanged.
//  Accept (registered, strobes high the cycle after the terminator byte):
//   - num_out = acc, num_valid = 1, num_idx = current index.
//   - Index 0: num_a = acc. num_b is unchanged. Index toggles to 1.
//   - Index 1: num_b = acc, pair_valid = 1 (same cycle as num_valid). Index toggles to 0.
//  err asserts the cycle after the offending byte. err and num_valid are never high together.
//  num_out, num_a, num_b and err_code hold between strobes.
//  Leading zeros count toward DIGITS ("007" is legal at DIGITS=3).
//  Reset or clr mid-number: the partial number is discarded, and parsing restarts with operand A.
// TESTING
//  1. "123\r\n045\n" -> num_valid 123 idx0; then num_valid 45 idx1 with pair_valid,
//     num_a=123, num_b=45; no output for the LF after CR.
//  2. "300\n" (WIDTH=8) -> err code 11 at '0'#3; no num_valid; then "7\n" -> num_out=7, idx0.
//  3. "12a4\n5\n" -> err code 01 one cycle after 'a'; '4' dropped; "5" -> num_valid 5 idx0.
//  4. "1234\n" (DIGITS=3) -> err code 10 on '4'; no output. "255\n" -> 255 accepted.
//  5. "\r\n\r\n" with rx_valid every cycle -> no strobes; state stays IDLE.
//  6. "9", "8", async reset pulse, then "6\n" -> num_valid 6, idx0; outputs 0 during reset.

Source files
------------

// File: rtl/uart_dec_line_parser.sv
// Turns an ASCII decimal byte stream (CR/LF terminated lines) into binary numbers
// and pairs successive numbers up as adder operands A and B.
module uart_dec_line_parser #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] num_out,
    output logic             num_valid,
    output logic             num_idx,
    output logic [WIDTH-1:0] num_a,
    output logic [WIDTH-1:0] num_b,
    output logic             pair_valid,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int AW = WIDTH + 4;

    localparam logic [1:0] CODE_BAD_CHAR = 2'b01;
    localparam logic [1:0] CODE_TOO_LONG = 2'b10;
    localparam logic [1:0] CODE_OVERFLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGITS,
        ST_DISCARD
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             idx;
    logic             accept, err_set;
    logic [1:0]       code_nxt;

    logic             is_digit, is_term;
    logic [3:0]       digit_val;
    logic [AW-1:0]    acc_wide, prod;
    logic             overflow, cnt_full;

    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign digit_val = rx_data[3:0];
    assign acc_wide  = {4'b0000, acc};
    // acc*10 + d as shifts; the 4 extra bits are enough to hold the worst case
    assign prod      = (acc_wide << 3) + (acc_wide << 1) + {{WIDTH{1'b0}}, digit_val};
    assign overflow  = prod > {4'b0000, {WIDTH{1'b1}}};
    assign cnt_full  = (cnt == CW'(DIGITS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_digit)      state_nxt = ST_DIGITS;
                    else if (!is_term) state_nxt = ST_DISCARD;
                end
                ST_DIGITS: begin
                    if (is_digit) begin
                        if (cnt_full || overflow) state_nxt = ST_DISCARD;
                    end else if (is_term) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (is_term) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_nxt  = acc;
        cnt_nxt  = cnt;
        accept   = 1'b0;
        err_set  = 1'b0;
        code_nxt = 2'b00;
        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_digit) begin
                        acc_nxt = WIDTH'(digit_val);
                        cnt_nxt = CW'(1);
                    end else if (!is_term) begin
                        err_set  = 1'b1;
                        code_nxt = CODE_BAD_CHAR;
                    end
                end
                ST_DIGITS: begin
                    if (is_digit) begin
                        if (cnt_full) begin
                            err_set  = 1'b1;
                            code_nxt = CODE_TOO_LONG;
                        end else if (overflow) begin
                            err_set  = 1'b1;
                            code_nxt = CODE_OVERFLOW;
                        end else begin
                            acc_nxt = prod[WIDTH-1:0];
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else if (is_term) begin
                        accept = 1'b1;
                    end else begin
                        err_set  = 1'b1;
                        code_nxt = CODE_BAD_CHAR;
                    end
                end
                default: ;
            endcase
        end
    end

    // idx is the slot the next accepted number fills; num_idx reports the slot of num_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            idx        <= 1'b0;
            num_out    <= '0;
            num_valid  <= 1'b0;
            num_idx    <= 1'b0;
            num_a      <= '0;
            num_b      <= '0;
            pair_valid <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else if (clr) begin
            acc        <= '0;
            cnt        <= '0;
            idx        <= 1'b0;
            num_out    <= '0;
            num_valid  <= 1'b0;
            num_idx    <= 1'b0;
            num_a      <= '0;
            num_b      <= '0;
            pair_valid <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            num_valid  <= accept;
            pair_valid <= accept && idx;
            err        <= err_set;
            if (err_set) err_code <= code_nxt;
            if (accept) begin
                num_out <= acc;
                num_idx <= idx;
                idx     <= ~idx;
                if (idx) num_b <= acc;
                else     num_a <= acc;
            end
        end
    end

endmodule

// File: tb/tb_uart_dec_line_parser.sv
// Drives directed and random ASCII streams into uart_dec_line_parser and compares
// every output against a line-level reference model after each clock.
module tb_uart_dec_line_parser;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int MAXV   = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clr = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic [WIDTH-1:0] num_out;
    logic             num_valid;
    logic             num_idx;
    logic [WIDTH-1:0] num_a;
    logic [WIDTH-1:0] num_b;
    logic             pair_valid;
    logic             err;
    logic [1:0]       err_code;

    uart_dec_line_parser #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .num_out(num_out), .num_valid(num_valid), .num_idx(num_idx),
        .num_a(num_a), .num_b(num_b), .pair_valid(pair_valid),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: value/digit count of the line so far, whether the line is being thrown away
    int m_val, m_cnt, m_idx;
    bit m_bad;
    int e_num_out, e_num_a, e_num_b, e_num_idx, e_err_code;
    bit e_nv, e_pv, e_err;

    task check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task model_reset();
        m_val = 0; m_cnt = 0; m_idx = 0; m_bad = 0;
        e_num_out = 0; e_num_a = 0; e_num_b = 0; e_num_idx = 0; e_err_code = 0;
        e_nv = 0; e_pv = 0; e_err = 0;
    endtask

    task model_error(input int code);
        e_err = 1; e_err_code = code; m_bad = 1; m_cnt = 0; m_val = 0;
    endtask

    task model_byte(input logic [7:0] b, input bit v);
        int v_new;
        e_nv = 0; e_pv = 0; e_err = 0;
        if (v) begin
            if (b >= 8'h30 && b <= 8'h39) begin
                if (!m_bad) begin
                    v_new = m_val * 10 + int'(b - 8'h30);
                    if (m_cnt == DIGITS)   model_error(2);
                    else if (v_new > MAXV) model_error(3);
                    else begin
                        m_val = v_new;
                        m_cnt++;
                    end
                end
            end else if (b == 8'h0D || b == 8'h0A) begin
                if (m_bad) begin
                    m_bad = 0;
                end else if (m_cnt > 0) begin
                    e_nv = 1; e_num_out = m_val; e_num_idx = m_idx;
                    if (m_idx == 0) e_num_a = m_val;
                    else begin
                        e_num_b = m_val;
                        e_pv = 1;
                    end
                    m_idx = 1 - m_idx;
                end
                m_cnt = 0; m_val = 0;
            end else if (!m_bad) begin
                model_error(1);
            end
        end
    endtask

    task check_all(input string tag);
        check_output({tag, ".num_valid"},  num_valid,  e_nv);
        check_output({tag, ".pair_valid"}, pair_valid, e_pv);
        check_output({tag, ".err"},        err,        e_err);
        check_output({tag, ".num_out"},    num_out,    e_num_out);
        check_output({tag, ".num_idx"},    num_idx,    e_num_idx);
        check_output({tag, ".num_a"},      num_a,      e_num_a);
        check_output({tag, ".num_b"},      num_b,      e_num_b);
        check_output({tag, ".err_code"},   err_code,   e_err_code);
    endtask

    task apply_stimulus(input logic [7:0] b, input bit v, input string tag);
        @(negedge clk);
        rx_data  = b;
        rx_valid = v;
        @(posedge clk);
        #1;
        model_byte(b, v);
        check_all(tag);
    endtask

    task send_string(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) apply_stimulus(s[i], 1'b1, tag);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task pulse_reset(input string tag);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    task pulse_clr(input string tag);
        @(negedge clk);
        clr      = 1'b1;
        rx_data  = 8'h31;
        rx_valid = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        clr      = 1'b0;
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] random_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 55) return 8'($urandom_range(8'h30, 8'h39));
        if (r < 80) return (r < 68) ? 8'h0A : 8'h0D;
        b = 8'($urandom_range(0, 255));
        if ((b >= 8'h30 && b <= 8'h39) || b == 8'h0A || b == 8'h0D) b = 8'h41;
        return b;
    endfunction

    initial begin
        model_reset();
        reset = 1'b1;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        send_string("123\r\n045\n", "t1");
        send_string("300\n", "t2a");
        send_string("7\n", "t2b");
        send_string("12a4\n5\n", "t3");
        send_string("1234\n", "t4a");
        send_string("255\n", "t4b");
        send_string("\r\n\r\n", "t5");
        send_string("98", "t6a");
        pulse_reset("t6rst");
        send_string("6\n", "t6b");
        send_string("007\n", "lead0");
        send_string("25", "clra");
        pulse_clr("clr");
        send_string("3\n", "clrb");
        send_string("256\n", "ovf");

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0)      pulse_clr("rnd.clr");
            else if (r == 1) pulse_reset("rnd.rst");
            else apply_stimulus(random_byte(), ($urandom_range(0, 9) < 7), "rnd");
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
